// File: rtl/frac_divider_if.sv
// ---------------------------------------------------------------------------
// frac_divider_if
//   Request/result bundle for the sequential fractional divider.
//   master : the block issuing divisions (drives start and operands)
//   slave  : the divider itself (returns busy/done and the result)
//   Signals:
//     start    request pulse, accepted when the divider is not busy
//     div_in1  dividend, unsigned Q0.n
//     div_in2  divisor, unsigned Q0.n
//     busy     iteration in progress
//     done     one-cycle pulse, div_out/div_err valid
//     div_out  quotient, unsigned Q0.n
//     div_err  divide-by-zero or quotient overflow
// ---------------------------------------------------------------------------
interface frac_divider_if #(
    parameter int n = 8
);
    logic         start;
    logic [n-1:0] div_in1;
    logic [n-1:0] div_in2;
    logic         busy;
    logic         done;
    logic [n-1:0] div_out;
    logic         div_err;

    modport master (
        output start, div_in1, div_in2,
        input  busy, done, div_out, div_err
    );

    modport slave (
        input  start, div_in1, div_in2,
        output busy, done, div_out, div_err
    );
endinterface

// File: rtl/frac_divider.sv
// ---------------------------------------------------------------------------
// frac_divider
//   Radix-2 restoring divider producing div_out = floor(div_in1 * 2^n / div_in2)
//   for unsigned Q0.n operands with div_in1 < div_in2. One quotient bit is
//   resolved per clock, MSB first, so a valid division takes n CALC cycles.
//   Zero divisor or div_in1 >= div_in2 saturates the quotient to all ones
//   and flags div_err, finishing one cycle after acceptance.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset, aborts any running division
//     bus  frac_divider_if slave modport (start/operands in, busy/done/result out)
// ---------------------------------------------------------------------------
module frac_divider #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             rst,
    frac_divider_if.slave    bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [n:0]     rem;
    logic [n-1:0]   den;
    logic [n-1:0]   quo;
    logic [CW-1:0]  count;
    logic [n-1:0]   result;
    logic           err;

    logic           accept;
    logic           in_err;
    logic [n+1:0]   t;
    logic           ge;
    logic [n:0]     diff;
    logic [n:0]     rem_nxt;
    logic [n-1:0]   quo_nxt;
    logic           last;

    // Quotient value reported when the true result does not fit in Q0.n.
    function automatic logic [n-1:0] saturate();
        return '1;
    endfunction

    always_comb begin
        accept  = bus.start && (state != CALC);
        in_err  = (bus.div_in2 == '0) || (bus.div_in1 >= bus.div_in2);

        // Trial subtraction of the shifted remainder. rem < den always holds,
        // so when ge is set the difference fits back into n+1 bits and only
        // the low bits of the subtraction need to be formed.
        t       = {rem, 1'b0};
        ge      = (t >= {2'b00, den});
        diff    = t[n:0] - {1'b0, den};
        rem_nxt = ge ? diff : t[n:0];
        quo_nxt = {quo[n-2:0], ge};
        last    = (count == CW'(1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = in_err ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            den    <= '0;
            quo    <= '0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            err <= in_err;
            if (in_err) begin
                result <= saturate();
            end else begin
                rem   <= {1'b0, bus.div_in1};
                den   <= bus.div_in2;
                quo   <= '0;
                count <= CW'(n);
            end
        end else if (state == CALC) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count - CW'(1);
            if (last) begin
                result <= quo_nxt;
            end
        end
    end

    assign bus.busy    = (state == CALC);
    assign bus.done    = (state == DONE);
    assign bus.div_out = result;
    assign bus.div_err = err;

endmodule

// File: tb/tb_frac_divider.sv
// ---------------------------------------------------------------------------
// tb_frac_divider
//   Directed bench for frac_divider (n = 8). Expected quotients are
//   hand-computed floor(a * 256 / b) values.
// ---------------------------------------------------------------------------
module tb_frac_divider;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    frac_divider_if #(.n(8)) bus ();

    frac_divider #(.n(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and wait for done. lat counts edges from the
    // accepting edge up to the first cycle showing done.
    task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic ee, input int elat);
        int lat;
        int busy_cnt;
        bus.start   = 1'b1;
        bus.div_in1 = a;
        bus.div_in2 = b;
        tick();
        bus.start   = 1'b0;
        bus.div_in1 = 8'hA5;
        bus.div_in2 = 8'h3C;
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 30) begin
            busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"},  lat, elat);
        check({tag, "_busy"}, busy_cnt, elat - 1);
        check({tag, "_out"},  bus.div_out, eo);
        check({tag, "_err"},  bus.div_err, ee);
        tick();
        check({tag, "_pulse"}, bus.done, 1'b0);
        check({tag, "_hold"},  bus.div_out, eo);
    endtask

    initial begin
        int   ndone;
        int   done_k;
        logic [7:0] cap;
        int   lat;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.div_in1 = '0;
        bus.div_in2 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_out",  bus.div_out, 8'h00);
        check("rst_err",  bus.div_err, 1'b0);

        // Basic divisions.
        do_div("t1_40_80", 8'h40, 8'h80, 8'h80, 1'b0, 9);
        do_div("t2_1_3",   8'h01, 8'h03, 8'h55, 1'b0, 9);
        do_div("t2_3_7",   8'h03, 8'h07, 8'h6D, 1'b0, 9);

        // Error cases: zero divisor, then saturation.
        do_div("t3_div0",  8'h12, 8'h00, 8'hFF, 1'b1, 1);
        do_div("t3_sat",   8'h90, 8'h90, 8'hFF, 1'b1, 1);

        // div_err clears on the next accepted start.
        bus.start   = 1'b1;
        bus.div_in1 = 8'h01;
        bus.div_in2 = 8'h02;
        tick();
        bus.start = 1'b0;
        check("t3_err_clr", bus.div_err, 1'b0);
        check("t3_busy",    bus.busy, 1'b1);
        lat = 1;
        while (!bus.done && lat < 30) begin
            tick();
            lat++;
        end
        check("t3_half", bus.div_out, 8'h80);
        tick();

        // Start pulses during CALC are ignored.
        bus.start   = 1'b1;
        bus.div_in1 = 8'h01;
        bus.div_in2 = 8'h03;
        tick();
        bus.start = 1'b0;
        ndone  = 0;
        done_k = 0;
        cap    = 8'h00;
        for (int k = 1; k <= 14; k++) begin
            bus.start   = (k == 3 || k == 5);
            bus.div_in1 = 8'h10;
            bus.div_in2 = 8'h20;
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                done_k = k;
                cap    = bus.div_out;
            end
        end
        check("t4_ndone", ndone, 1);
        check("t4_when",  done_k, 8);
        check("t4_out",   cap, 8'h55);

        // Reset mid-operation aborts without a done pulse.
        bus.start   = 1'b1;
        bus.div_in1 = 8'h40;
        bus.div_in2 = 8'h80;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("t5_running", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_done", bus.done, 1'b0);
        check("t5_out",  bus.div_out, 8'h00);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.done) ndone++;
        end
        check("t5_nodone", ndone, 0);
        do_div("t5_20_80", 8'h20, 8'h80, 8'h40, 1'b0, 9);

        // Back-to-back with start held high.
        bus.start   = 1'b1;
        bus.div_in1 = 8'h40;
        bus.div_in2 = 8'h80;
        tick();
        lat = 1;
        while (!bus.done && lat < 30) begin
            tick();
            lat++;
        end
        check("t6_lat1", lat, 9);
        check("t6_out1", bus.div_out, 8'h80);
        bus.div_in1 = 8'h01;
        bus.div_in2 = 8'h03;
        tick();
        bus.start = 1'b0;
        check("t6_nogap", bus.busy, 1'b1);
        lat = 1;
        while (!bus.done && lat < 30) begin
            tick();
            lat++;
        end
        check("t6_lat2", lat, 9);
        check("t6_out2", bus.div_out, 8'h55);
        check("t6_err2", bus.div_err, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
